commit_trace_ctrl: RTL and testbench
====================================

COMMIT_TRACE_CTRL -- requirements
Module: commit_trace_ctrl

Interface
REQ-001 Parameter DEPTH, default 8, number of trace FIFO entries; power of two, at least 4.
REQ-002 Parameter CNTW, default 16, width of the step counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset; asynchronous assert, active-low.
REQ-005 commit_valid  input  1  core writeback commit strobe.
REQ-006 commit_pc  input  32  PC of the committing instruction.
REQ-007 commit_rd  input  5  destination register of the commit.
REQ-008 commit_data  input  32  value written to commit_rd.
REQ-009 cmd_valid  input  1  run-control command strobe; always accepted, with no ready signal.
REQ-010 cmd_op  input  2  command: 00 HALT, 01 RUN, 10 STEP, 11 CLR_OVF.
REQ-011 cmd_count  input  CNTW  number of commits for STEP.
REQ-012 core_stall  output  1  freeze request to the core pipeline.
REQ-013 trace_valid  output  1  FIFO head record is valid.
REQ-014 trace_ready  input  1  consumer accepts the head record.
REQ-015 trace_pc / trace_rd / trace_data  output  32/5/32  FIFO head record.
REQ-016 state  output  2  FSM state: 00 IDLE, 01 RUN, 10 STEP, 11 HALTED.
REQ-017 overflow  output  1  sticky flag: a commit was dropped.
REQ-018 level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-019 Capture condition: commit_valid=1 and commit_rd!=0; commits to x0 are neither stored nor counted.
REQ-020 A commit captured at edge N SHALL appear at the FIFO head no earlier than cycle N+1; with an empty FIFO, trace_valid rises in cycle N+1.
REQ-021 Pop condition: trace_valid and trace_ready both high; records leave in capture order.
REQ-022 Commits SHALL be captured in every state, including IDLE and HALTED, because of in-flight pipeline writebacks.
REQ-023 Full FIFO with a capture and no pop: the record is dropped, level is unchanged, and overflow is set.
REQ-024 Full FIFO with a capture and a pop in the same cycle: the capture is accepted and level is unchanged.
REQ-025 Empty FIFO: trace_valid=0; trace_* hold their last value, and their content is don't-care.
REQ-026 FSM transitions on cmd_valid:
  - HALT: from any state to HALTED.
  - RUN: IDLE/HALTED to RUN; ignored in RUN/STEP.
  - STEP with cmd_count>0: IDLE/HALTED to STEP, loading the counter with cmd_count.
  - STEP with cmd_count=0: no-op.
  - STEP while in RUN/STEP: ignored.
  - CLR_OVF: clears overflow; no state change.
REQ-027 In STEP, each capture decrements the counter; the capture that brings it to 0 moves the FSM to HALTED at the same edge.
REQ-028 A HALT command in the same cycle as the final STEP capture SHALL give HALTED, and the capture SHALL still be stored.
REQ-029 core_stall is registered and SHALL be 1 when state is IDLE or HALTED, or when level >= DEPTH-2 (two slots of headroom for in-flight commits); otherwise 0.
REQ-030 A commit that overflows in the same cycle as CLR_OVF SHALL leave overflow set (set wins).
REQ-031 Pointer arithmetic wraps modulo DEPTH; level never exceeds DEPTH.

Reset
REQ-032 While reset_n=0: state=IDLE, FIFO empty, level=0, trace_valid=0, overflow=0, step counter=0, core_stall=1, and trace_pc/rd/data=0.
REQ-033 Reset asserted mid-operation SHALL discard all FIFO contents and the step count immediately.
REQ-034 After reset_n deasserts, the FSM SHALL stay in IDLE until a RUN or STEP command arrives.

Structure
REQ-035 Package commit_trace_pkg SHALL hold ctrl_state_e, cmd_op_e, and trace_rec_t (pc, rd, data).
REQ-036 Storage SHALL be one sub-module, trace_fifo, parameterised by DEPTH and the record type; the FSM, step counter, overflow flag and stall logic stay in the top level.

Verification
REQ-037 Reset, then RUN, then 3 commits (rd=1,2,3; pc 0x0, 0x4, 0x8) with trace_ready=1: three records appear in order, each one cycle after its commit; core_stall=0 during RUN.
REQ-038 STEP with cmd_count=2, then commits rd=5, rd=0, rd=6: the rd=0 commit is dropped; state is HALTED at the edge of the rd=6 capture; core_stall=1 the cycle after.
REQ-039 RUN with trace_ready=0 and DEPTH=8: core_stall rises when level reaches 6; 3 further commits fill the FIFO to 8; the 3rd sets overflow; CLR_OVF then clears it.
REQ-040 Full FIFO with a simultaneous capture and pop: level stays 8, overflow stays 0, and the head advances by one.
REQ-041 Drive reset_n low with level=5 and state=STEP: outputs take reset values asynchronously, before the next clk edge.
REQ-042 HALT issued while in RUN with a commit in the same cycle: state=HALTED and the commit is still captured.

Source files
------------

// File: rtl/commit_trace_pkg.sv
// Shared types for the commit trace controller: FSM states, run-control
// opcodes and the captured commit record.
package commit_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_STEP   = 2'b10,
    ST_HALTED = 2'b11
  } ctrl_state_e;

  typedef enum logic [1:0] {
    OP_HALT    = 2'b00,
    OP_RUN     = 2'b01,
    OP_STEP    = 2'b10,
    OP_CLR_OVF = 2'b11
  } cmd_op_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
  } trace_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// Trace record FIFO with a registered head so a record written into an empty
// queue is visible the cycle after capture and the head resets to zero.
module trace_fifo
  import commit_trace_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type rec_t = trace_rec_t
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  rec_t                    wdata,
  input  logic                    ready,
  output rec_t                    head,
  output logic                    valid,
  output logic                    drop,
  output logic [$clog2(DEPTH):0]  level,
  output logic [$clog2(DEPTH):0]  level_next
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  rec_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_ptr_inc;
  logic [LW-1:0] cnt;
  logic          full;
  logic          pop;
  logic          wr;

  assign valid      = (cnt != '0);
  assign full       = (cnt == LW'(DEPTH));
  assign pop        = valid & ready;
  // A pop frees the slot in the same cycle, so a full queue still accepts.
  assign wr         = push & (~full | pop);
  assign drop       = push & full & ~pop;
  assign rd_ptr_inc = rd_ptr + PW'(1);
  assign level      = cnt;
  assign level_next = cnt + LW'(wr) - LW'(pop);

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      head   <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr_inc;
      cnt <= level_next;
      // Head tracks the entry that will sit at rd_ptr after this edge;
      // when the queue drains it simply holds its last value.
      if (pop && cnt > LW'(1))
        head <= mem[rd_ptr_inc];
      else if (wr && (cnt == '0 || (pop && cnt == LW'(1))))
        head <= wdata;
    end
  end

endmodule

// File: rtl/commit_trace_ctrl.sv
// Run-control FSM with single-step counter, sticky overflow and core stall
// generation around a FIFO of committed-instruction trace records.
module commit_trace_ctrl
  import commit_trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNTW  = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   commit_valid,
  input  logic [31:0]            commit_pc,
  input  logic [4:0]             commit_rd,
  input  logic [31:0]            commit_data,
  input  logic                   cmd_valid,
  input  logic [1:0]             cmd_op,
  input  logic [CNTW-1:0]        cmd_count,
  output logic                   core_stall,
  output logic                   trace_valid,
  input  logic                   trace_ready,
  output logic [31:0]            trace_pc,
  output logic [4:0]             trace_rd,
  output logic [31:0]            trace_data,
  output logic [1:0]             state,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level
);

  localparam int LW = $clog2(DEPTH) + 1;

  ctrl_state_e   state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic          overflow_d;
  logic          stall_d;
  logic          capture;
  logic          drop;
  logic          halted_or_idle;
  logic [LW-1:0] level_next;
  trace_rec_t    wrec;
  trace_rec_t    head;

  // x0 writebacks carry no architectural state, so they are not traced.
  assign capture        = commit_valid && (commit_rd != 5'd0);
  assign halted_or_idle = (state_q == ST_IDLE) || (state_q == ST_HALTED);
  assign wrec           = '{pc: commit_pc, rd: commit_rd, data: commit_data};

  trace_fifo #(
    .DEPTH (DEPTH),
    .rec_t (trace_rec_t)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (reset_n),
    .push       (capture),
    .wdata      (wrec),
    .ready      (trace_ready),
    .head       (head),
    .valid      (trace_valid),
    .drop       (drop),
    .level      (level),
    .level_next (level_next)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_STEP && capture) begin
      cnt_d = cnt_q - CNTW'(1);
      if (cnt_q == CNTW'(1)) state_d = ST_HALTED;
    end
    // Commands are applied after the step decrement so HALT always wins.
    if (cmd_valid) begin
      case (cmd_op_e'(cmd_op))
        OP_HALT: begin
          state_d = ST_HALTED;
          cnt_d   = '0;
        end
        OP_RUN: begin
          if (halted_or_idle) state_d = ST_RUN;
        end
        OP_STEP: begin
          if (halted_or_idle && cmd_count != '0) begin
            state_d = ST_STEP;
            cnt_d   = cmd_count;
          end
        end
        default: ;
      endcase
    end
  end

  assign overflow_d = drop | (overflow && !(cmd_valid && cmd_op_e'(cmd_op) == OP_CLR_OVF));
  // Two slots of headroom cover commits already in flight when stall rises.
  assign stall_d    = (state_d == ST_IDLE) || (state_d == ST_HALTED) ||
                      (level_next >= LW'(DEPTH - 2));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      overflow   <= 1'b0;
      core_stall <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      overflow   <= overflow_d;
      core_stall <= stall_d;
    end
  end

  assign state      = state_q;
  assign trace_pc   = head.pc;
  assign trace_rd   = head.rd;
  assign trace_data = head.data;

endmodule

// File: tb/tb_commit_trace_ctrl.sv
// Directed bench for commit_trace_ctrl: run, step, fill/overflow, full
// push+pop, HALT collisions and asynchronous reset.
module tb_commit_trace_ctrl;

  localparam int DEPTH = 8;
  localparam int CNTW  = 16;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            commit_valid;
  logic [31:0]     commit_pc;
  logic [4:0]      commit_rd;
  logic [31:0]     commit_data;
  logic            cmd_valid;
  logic [1:0]      cmd_op;
  logic [CNTW-1:0] cmd_count;
  logic            core_stall;
  logic            trace_valid;
  logic            trace_ready;
  logic [31:0]     trace_pc;
  logic [4:0]      trace_rd;
  logic [31:0]     trace_data;
  logic [1:0]      state;
  logic            overflow;
  logic [3:0]      level;

  int total_cnt = 0;
  int pass_cnt  = 0;

  always #5 clk = ~clk;

  commit_trace_ctrl #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .commit_valid (commit_valid),
    .commit_pc    (commit_pc),
    .commit_rd    (commit_rd),
    .commit_data  (commit_data),
    .cmd_valid    (cmd_valid),
    .cmd_op       (cmd_op),
    .cmd_count    (cmd_count),
    .core_stall   (core_stall),
    .trace_valid  (trace_valid),
    .trace_ready  (trace_ready),
    .trace_pc     (trace_pc),
    .trace_rd     (trace_rd),
    .trace_data   (trace_data),
    .state        (state),
    .overflow     (overflow),
    .level        (level)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    commit_valid = 1'b0; commit_pc = '0; commit_rd = '0; commit_data = '0;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_count = '0;
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [CNTW-1:0] n);
    cmd_valid = 1'b1; cmd_op = op; cmd_count = n;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic set_commit(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] data);
    commit_valid = 1'b1; commit_pc = pc; commit_rd = rd; commit_data = data;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; trace_ready = 1'b0; set_idle();
    tick(); tick();
    total_cnt++; if (state !== 2'd0) $display("FAIL rst_state: got %0d expected 0", state); else pass_cnt++;
    total_cnt++; if (level !== 4'd0) $display("FAIL rst_level: got %0d expected 0", level); else pass_cnt++;
    total_cnt++; if (trace_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", trace_valid); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0) $display("FAIL rst_ovf: got %b expected 0", overflow); else pass_cnt++;
    total_cnt++; if (core_stall !== 1'b1) $display("FAIL rst_stall: got %b expected 1", core_stall); else pass_cnt++;
    total_cnt++; if ({trace_pc, trace_rd, trace_data} !== 69'd0) $display("FAIL rst_head: got %h expected 0", {trace_pc, trace_rd, trace_data}); else pass_cnt++;
    reset_n = 1'b1;
    tick(); tick();
    total_cnt++; if (state !== 2'd0) $display("FAIL idle_hold: got %0d expected 0", state); else pass_cnt++;
    total_cnt++; if (core_stall !== 1'b1) $display("FAIL idle_stall: got %b expected 1", core_stall); else pass_cnt++;
    set_commit(32'h40, 5'd4, 32'h44);
    tick();
    commit_valid = 1'b0;
    total_cnt++; if (level !== 4'd1) $display("FAIL idle_capture_level: got %0d expected 1", level); else pass_cnt++;
    total_cnt++; if (trace_rd !== 5'd4) $display("FAIL idle_capture_rd: got %0d expected 4", trace_rd); else pass_cnt++;
    trace_ready = 1'b1;
    tick();
    total_cnt++; if (trace_valid !== 1'b0) $display("FAIL idle_drain: got %b expected 0", trace_valid); else pass_cnt++;
  endtask

  task automatic test_run();
    trace_ready = 1'b1;
    do_cmd(2'b01, '0);
    total_cnt++; if (state !== 2'd1) $display("FAIL run_state: got %0d expected 1", state); else pass_cnt++;
    total_cnt++; if (core_stall !== 1'b0) $display("FAIL run_stall: got %b expected 0", core_stall); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      set_commit(32'(i * 4), 5'(i + 1), 32'hA0 + 32'(i));
      tick();
      total_cnt++; if (trace_valid !== 1'b1) $display("FAIL run_valid%0d: got %b expected 1", i, trace_valid); else pass_cnt++;
      total_cnt++; if (trace_pc !== 32'(i * 4)) $display("FAIL run_pc%0d: got %h expected %h", i, trace_pc, i * 4); else pass_cnt++;
      total_cnt++; if (trace_rd !== 5'(i + 1)) $display("FAIL run_rd%0d: got %0d expected %0d", i, trace_rd, i + 1); else pass_cnt++;
      total_cnt++; if (trace_data !== 32'hA0 + 32'(i)) $display("FAIL run_data%0d: got %h expected %h", i, trace_data, 32'hA0 + i); else pass_cnt++;
      total_cnt++; if (core_stall !== 1'b0) $display("FAIL run_stall%0d: got %b expected 0", i, core_stall); else pass_cnt++;
    end
    commit_valid = 1'b0;
    tick();
    total_cnt++; if (level !== 4'd0) $display("FAIL run_drain: got %0d expected 0", level); else pass_cnt++;
  endtask

  task automatic test_step();
    do_cmd(2'b00, '0);
    total_cnt++; if (state !== 2'd3) $display("FAIL halt_state: got %0d expected 3", state); else pass_cnt++;
    total_cnt++; if (core_stall !== 1'b1) $display("FAIL halt_stall: got %b expected 1", core_stall); else pass_cnt++;
    do_cmd(2'b10, 16'd0);
    total_cnt++; if (state !== 2'd3) $display("FAIL step0_noop: got %0d expected 3", state); else pass_cnt++;
    do_cmd(2'b10, 16'd2);
    total_cnt++; if (state !== 2'd2) $display("FAIL step_state: got %0d expected 2", state); else pass_cnt++;
    total_cnt++; if (core_stall !== 1'b0) $display("FAIL step_stall: got %b expected 0", core_stall); else pass_cnt++;
    do_cmd(2'b01, '0);
    total_cnt++; if (state !== 2'd2) $display("FAIL step_run_ignored: got %0d expected 2", state); else pass_cnt++;
    set_commit(32'h10, 5'd5, 32'h55);
    tick();
    total_cnt++; if (trace_rd !== 5'd5) $display("FAIL step_rd5: got %0d expected 5", trace_rd); else pass_cnt++;
    total_cnt++; if (state !== 2'd2) $display("FAIL step_after1: got %0d expected 2", state); else pass_cnt++;
    set_commit(32'h14, 5'd0, 32'h99);
    tick();
    total_cnt++; if (trace_valid !== 1'b0) $display("FAIL step_x0_dropped: got %b expected 0", trace_valid); else pass_cnt++;
    total_cnt++; if (state !== 2'd2) $display("FAIL step_x0_uncounted: got %0d expected 2", state); else pass_cnt++;
    set_commit(32'h18, 5'd6, 32'h66);
    tick();
    commit_valid = 1'b0;
    total_cnt++; if (state !== 2'd3) $display("FAIL step_done_state: got %0d expected 3", state); else pass_cnt++;
    total_cnt++; if (trace_rd !== 5'd6) $display("FAIL step_rd6: got %0d expected 6", trace_rd); else pass_cnt++;
    total_cnt++; if (core_stall !== 1'b1) $display("FAIL step_done_stall: got %b expected 1", core_stall); else pass_cnt++;
    tick();
  endtask

  task automatic test_fill_overflow();
    trace_ready = 1'b0;
    do_cmd(2'b01, '0);
    total_cnt++; if (state !== 2'd1) $display("FAIL fill_run: got %0d expected 1", state); else pass_cnt++;
    for (int i = 1; i <= 9; i++) begin
      int exp_lvl;
      exp_lvl = (i > 8) ? 8 : i;
      set_commit(32'(i * 4), 5'(i), 32'(i));
      tick();
      total_cnt++; if (level !== exp_lvl[3:0]) $display("FAIL fill_level%0d: got %0d expected %0d", i, level, exp_lvl); else pass_cnt++;
      total_cnt++; if (core_stall !== (i >= 6)) $display("FAIL fill_stall%0d: got %b expected %b", i, core_stall, i >= 6); else pass_cnt++;
      total_cnt++; if (overflow !== (i == 9)) $display("FAIL fill_ovf%0d: got %b expected %b", i, overflow, i == 9); else pass_cnt++;
    end
    commit_valid = 1'b0;
    total_cnt++; if (trace_rd !== 5'd1 || trace_pc !== 32'h4) $display("FAIL fill_head: got rd %0d pc %h expected rd 1 pc 4", trace_rd, trace_pc); else pass_cnt++;
    do_cmd(2'b11, '0);
    total_cnt++; if (overflow !== 1'b0) $display("FAIL clr_ovf: got %b expected 0", overflow); else pass_cnt++;
    total_cnt++; if (state !== 2'd1) $display("FAIL clr_state: got %0d expected 1", state); else pass_cnt++;
    set_commit(32'h50, 5'd20, 32'h20);
    cmd_valid = 1'b1; cmd_op = 2'b11;
    tick();
    commit_valid = 1'b0; cmd_valid = 1'b0;
    total_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_set_wins: got %b expected 1", overflow); else pass_cnt++;
    total_cnt++; if (level !== 4'd8) $display("FAIL ovf_level: got %0d expected 8", level); else pass_cnt++;
    do_cmd(2'b11, '0);
    total_cnt++; if (overflow !== 1'b0) $display("FAIL clr_ovf2: got %b expected 0", overflow); else pass_cnt++;
  endtask

  task automatic test_full_push_pop();
    int exp_rd [8] = '{2, 3, 4, 5, 6, 7, 8, 10};
    trace_ready = 1'b1;
    set_commit(32'd40, 5'd10, 32'd10);
    tick();
    commit_valid = 1'b0;
    total_cnt++; if (level !== 4'd8) $display("FAIL fpp_level: got %0d expected 8", level); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0) $display("FAIL fpp_ovf: got %b expected 0", overflow); else pass_cnt++;
    for (int k = 0; k < 8; k++) begin
      total_cnt++;
      if (trace_rd !== 5'(exp_rd[k]) || trace_pc !== 32'(exp_rd[k] * 4) || trace_data !== 32'(exp_rd[k]))
        $display("FAIL fpp_order%0d: got rd %0d pc %h data %h expected rd %0d", k, trace_rd, trace_pc, trace_data, exp_rd[k]);
      else pass_cnt++;
      tick();
    end
    total_cnt++; if (trace_valid !== 1'b0 || level !== 4'd0) $display("FAIL fpp_empty: got valid %b level %0d expected 0 0", trace_valid, level); else pass_cnt++;
  endtask

  task automatic test_halt_same_cycle();
    trace_ready = 1'b0;
    set_commit(32'h100, 5'd7, 32'h77);
    cmd_valid = 1'b1; cmd_op = 2'b00;
    tick();
    commit_valid = 1'b0; cmd_valid = 1'b0;
    total_cnt++; if (state !== 2'd3) $display("FAIL halt_run_state: got %0d expected 3", state); else pass_cnt++;
    total_cnt++; if (level !== 4'd1 || trace_rd !== 5'd7) $display("FAIL halt_run_capture: got level %0d rd %0d expected 1 7", level, trace_rd); else pass_cnt++;
    do_cmd(2'b10, 16'd1);
    total_cnt++; if (state !== 2'd2) $display("FAIL step1_state: got %0d expected 2", state); else pass_cnt++;
    set_commit(32'h104, 5'd9, 32'h99);
    cmd_valid = 1'b1; cmd_op = 2'b00;
    tick();
    commit_valid = 1'b0; cmd_valid = 1'b0;
    total_cnt++; if (state !== 2'd3) $display("FAIL halt_step_state: got %0d expected 3", state); else pass_cnt++;
    total_cnt++; if (level !== 4'd2) $display("FAIL halt_step_capture: got %0d expected 2", level); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    do_cmd(2'b10, 16'd10);
    for (int i = 0; i < 3; i++) begin
      set_commit(32'h200 + 32'(i * 4), 5'(11 + i), 32'(i));
      tick();
    end
    commit_valid = 1'b0;
    total_cnt++; if (level !== 4'd5 || state !== 2'd2) $display("FAIL pre_rst: got level %0d state %0d expected 5 2", level, state); else pass_cnt++;
    #2;
    reset_n = 1'b0;
    #1;
    total_cnt++; if (state !== 2'd0) $display("FAIL async_state: got %0d expected 0", state); else pass_cnt++;
    total_cnt++; if (level !== 4'd0 || trace_valid !== 1'b0) $display("FAIL async_fifo: got level %0d valid %b expected 0 0", level, trace_valid); else pass_cnt++;
    total_cnt++; if (core_stall !== 1'b1) $display("FAIL async_stall: got %b expected 1", core_stall); else pass_cnt++;
    total_cnt++; if (trace_pc !== 32'd0 || trace_rd !== 5'd0) $display("FAIL async_head: got pc %h rd %0d expected 0 0", trace_pc, trace_rd); else pass_cnt++;
    tick();
    reset_n = 1'b1;
    tick(); tick();
    total_cnt++; if (state !== 2'd0) $display("FAIL post_rst_idle: got %0d expected 0", state); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_run();
    test_step();
    test_fill_overflow();
    test_full_push_pop();
    test_halt_same_cycle();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
